// File: rtl/lab4_pkg.sv
// Shared definitions for the lab4 serial path: FSM state width and encodings.
package lab4_pkg;

    localparam int unsigned StateW = 3;

    typedef enum logic [StateW-1:0] {
        StIdle   = 3'd0,
        StStart  = 3'd1,
        StData   = 3'd2,
        StParity = 3'd3,
        StStop   = 3'd4
    } state_e;

endpackage

// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: start bit (1), data MSB-first, even parity, stop bit (0).
// Idle line level is 0; all outputs decode from registered state only.
module serial_frame_tx
    import lab4_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid,
    input  logic [WIDTH-1:0]  data,
    output logic              ready,
    output logic              out,
    output logic              busy,
    output logic              done,
    output logic [StateW-1:0] state
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             par_q, par_d;
    logic [CntW-1:0]  cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            shreg_q <= '0;
            par_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            par_q   <= par_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        par_d   = par_q;
        cnt_d   = cnt_q;
        out     = 1'b0;
        ready   = 1'b0;
        busy    = 1'b1;
        done    = 1'b0;
        case (state_q)
            StIdle: begin
                ready = 1'b1;
                busy  = 1'b0;
                if (valid) begin
                    shreg_d = data;
                    par_d   = ^data;
                    state_d = StStart;
                end
            end
            StStart: begin
                out     = 1'b1;
                cnt_d   = '0;
                state_d = StData;
            end
            StData: begin
                out     = shreg_q[WIDTH-1];
                shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
                cnt_d   = cnt_q + CntW'(1);
                if (cnt_q == CntLast) begin
                    state_d = StParity;
                end
            end
            StParity: begin
                out     = par_q;
                state_d = StStop;
            end
            StStop: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            // Unused codes recover to idle on the next clock.
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign state = state_q;

endmodule

// File: doc/serial_frame_tx.md
# serial_frame_tx

Serial frame transmitter for the lab4 serial path. It accepts a parallel word over a valid/ready handshake and emits it one bit per clock on a single-bit line: start bit, data MSB-first, even parity bit, stop bit. It is the sending end that produces the `in` bit stream consumed by the lab's serial receivers and FSMs. It exposes its FSM state for board LEDs and debug.

## Interface
Parameters:
- `WIDTH`, 8, number of data bits per frame; legal range 2..16.

Ports:
- `clk`, input, 1, single clock; all logic on posedge.
- `rst_n`, input, 1, synchronous, active-low reset, sampled on posedge `clk`.
- `valid`, input, 1, `data` is offered this cycle.
- `data`, input, WIDTH, word to transmit; sampled only on handshake.
- `ready`, output, 1, transmitter can accept a word this cycle.
- `out`, output, 1, serial line.
- `busy`, output, 1, a frame is in progress (any state other than IDLE).
- `done`, output, 1, high for exactly the STOP cycle of each frame.
- `state`, output, 3, current FSM state encoding.

## Operation
- Reset values: `state`=IDLE, `ready`=1, `out`=0, `busy`=0, `done`=0. Shift register and counter are cleared.
- State encodings: IDLE=3'd0, START=3'd1, DATA=3'd2, PARITY=3'd3, STOP=3'd4. Codes 5–7 are illegal and return to IDLE on the next clock.
- Handshake: a word is accepted when `valid && ready`. `ready` = (state==IDLE). On accept, latch `data` into the shift register and compute parity = ^data. Next state is START.
- START: `out`=1 for one cycle, then DATA with bit counter = 0.
- DATA: `out`=shreg[WIDTH-1]. Each cycle, shift left by 1 and increment the counter. After WIDTH cycles, go to PARITY.
- PARITY: `out`=latched parity (even parity: total count of ones in data+parity is even). Lasts one cycle, then STOP.
- STOP: `out`=0 and `done`=1 for one cycle, then IDLE.
- IDLE: `out`=0. Line idle level is 0.
- `out`, `busy`, `ready` and `done` decode from registered state and shift register only. There is no combinational path from `valid` or `data` to any output.
- `valid` or `data` changes while busy are ignored; the in-flight frame is unaffected.
- Reset asserted mid-frame: on the next posedge, return to IDLE with all reset values. The partial frame is dropped; no `done` is produced.

## Timing
- Handshake at edge t puts START on `out` during cycle t+1.
- Data bit k (k=0 is the MSB) appears in cycle t+2+k. PARITY is in cycle t+WIDTH+2, STOP in cycle t+WIDTH+3.
- IDLE resumes at t+WIDTH+4 with `ready`=1. The earliest next accept is edge t+WIDTH+4, which gives a minimum frame period of WIDTH+4 cycles (12 for WIDTH=8).
- There is at least one IDLE cycle (`out`=0) between back-to-back frames.
- Bit counter width is $clog2(WIDTH+1). Terminal count is WIDTH-1, compared in the counter's width with no overflow.

## Structure
- Shared package `lab4_pkg`: the five state constants, and the 3-bit state width as a localparam.
- Single module. No sub-module is warranted; parity is one reduction XOR and the counter is inline.
- Two processes: a state/datapath register block with the synchronous reset, and a combinational next-state/output decode.

## Test plan
- Reset, then `valid`=1 with `data`=8'hA5 -> `out` sequence 1,1,0,1,0,0,1,0,1,0,0 over cycles t+1..t+11. `done` is high only at t+11. `ready` returns at t+12.
- `data`=8'h01 -> parity bit 1. Full sequence: 1,0,0,0,0,0,0,0,1,1,0.
- `valid` held high with `data`=8'h00 then 8'hFF -> the second accept occurs exactly 12 cycles after the first. Each frame has a correct parity of 0, and `out`=0 for at least one cycle between frames.
- During the DATA state, toggle `data` to random values with `valid`=1 -> the transmitted bits still equal the latched word, and `ready` stays 0.
- Send 8'hC3 and assert `rst_n`=0 for one cycle during the data bit k=3 cycle -> the next cycle shows `state`=0, `out`=0, `ready`=1, and no `done` pulse. A subsequent 8'h3C frame transmits correctly.
- Instantiate with WIDTH=2 and send 2'b10 -> `out` sequence 1,1,0,1,0, with a frame period of 6 cycles.
